// File: rtl/dmem_arbiter_if.sv
// Data-memory arbitration bundle: CPU MEM-stage port, filter read port and the shared memory port.
// The arbiter takes the slave modport; requesters/memory models take the master modport.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [2:0]        cpu_func3;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_stall;
    logic [31:0]       cpu_rdata;
    logic              cpu_rvalid;

    logic              flt_req;
    logic [ADDR_W-1:0] flt_addr;
    logic              flt_gnt;
    logic [31:0]       flt_rdata;
    logic              flt_rvalid;

    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [2:0]        mem_func3;
    logic              mem_we;
    logic [31:0]       mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_func3, cpu_addr, cpu_wdata,
        input  flt_req, flt_addr, mem_rdata,
        output cpu_stall, cpu_rdata, cpu_rvalid,
        output flt_gnt, flt_rdata, flt_rvalid,
        output mem_addr, mem_wdata, mem_func3, mem_we
    );

    modport master (
        output cpu_req, cpu_we, cpu_func3, cpu_addr, cpu_wdata,
        output flt_req, flt_addr, mem_rdata,
        input  cpu_stall, cpu_rdata, cpu_rvalid,
        input  flt_gnt, flt_rdata, flt_rvalid,
        input  mem_addr, mem_wdata, mem_func3, mem_we
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single data-memory port shared by the CPU MEM stage (priority) and the filter window-fetch engine.
// Define DMEM_ARB_STARVE_GUARD_EN to force a starved filter request through after STARVE_LIMIT denied cycles.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic            clk,
    input  logic            rst,
    dmem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_FLT  = 2'b10
    } owner_t;

    owner_t rd_owner_r;
    logic   cpu_gnt_s;
    logic   flt_gnt_s;
    logic   force_flt_s;

    if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_limit
        $error("dmem_arbiter: STARVE_LIMIT must lie in 1..15");
    end

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt_r;

    // Count consecutive denied filter cycles, saturating at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_r <= 4'd0;
        end else if (!bus.flt_req || flt_gnt_s) begin
            starve_cnt_r <= 4'd0;
        end else if (starve_cnt_r != LIMIT) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    assign force_flt_s = (starve_cnt_r == LIMIT);
`else
    assign force_flt_s = 1'b0;
`endif

    // Combinational grant; both grants are held off while reset is asserted.
    always_comb begin
        cpu_gnt_s = rst & bus.cpu_req & ~force_flt_s;
        flt_gnt_s = rst & bus.flt_req & (~bus.cpu_req | force_flt_s);
    end

    // Steer the winner onto the memory port; idle port drives all zeros.
    always_comb begin
        bus.mem_addr  = {ADDR_W{1'b0}};
        bus.mem_wdata = 32'd0;
        bus.mem_func3 = 3'b000;
        bus.mem_we    = 1'b0;
        if (cpu_gnt_s) begin
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
            bus.mem_func3 = bus.cpu_func3;
            bus.mem_we    = bus.cpu_we;
        end else if (flt_gnt_s) begin
            bus.mem_addr  = bus.flt_addr;
            bus.mem_wdata = 32'd0;
            bus.mem_func3 = 3'b010;
            bus.mem_we    = 1'b0;
        end else begin
            bus.mem_addr  = {ADDR_W{1'b0}};
            bus.mem_wdata = 32'd0;
            bus.mem_func3 = 3'b000;
            bus.mem_we    = 1'b0;
        end
    end

    // Owner tag for next cycle's read data; stores produce no return.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_owner_r <= OWN_NONE;
        end else begin
            case ({cpu_gnt_s & ~bus.cpu_we, flt_gnt_s})
                2'b10:   rd_owner_r <= OWN_CPU;
                2'b01:   rd_owner_r <= OWN_FLT;
                default: rd_owner_r <= OWN_NONE;
            endcase
        end
    end

    assign bus.flt_gnt    = flt_gnt_s;
    assign bus.cpu_stall  = rst & bus.cpu_req & ~cpu_gnt_s;
    assign bus.cpu_rvalid = (rd_owner_r == OWN_CPU);
    assign bus.flt_rvalid = (rd_owner_r == OWN_FLT);
    assign bus.cpu_rdata  = (rd_owner_r == OWN_CPU) ? bus.mem_rdata : 32'd0;
    assign bus.flt_rdata  = (rd_owner_r == OWN_FLT) ? bus.mem_rdata : 32'd0;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single data-memory port between the CPU MEM stage and the ROF-filter window-fetch engine. At most one access is issued per cycle. Read data is returned to the owner one cycle after its grant. The CPU stalls whenever it loses arbitration. An optional starvation guard ensures the filter engine eventually wins against a continuously requesting CPU.

## Interface
- STARVE_LIMIT, 4: consecutive denied filter-request cycles before the filter is forced through (1..15).
- ADDR_W, 32: address width of both requesters and the memory port.
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request (load or store).
- cpu_we  in  1  1 = store, 0 = load.
- cpu_func3  in  3  access size/sign code, forwarded unchanged to memory.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  32  store data.
- cpu_stall  out  1  cpu_req & ~cpu_gnt; holds the CPU pipeline.
- cpu_rdata  out  32  load data, valid when cpu_rvalid.
- cpu_rvalid  out  1  CPU load data valid this cycle.
- flt_req  in  1  filter word-read request; read-only port.
- flt_addr  in  ADDR_W  word-aligned byte address.
- flt_gnt  out  1  filter request accepted this cycle.
- flt_rdata  out  32  read data, valid when flt_rvalid.
- flt_rvalid  out  1  filter read data valid this cycle.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  32  memory write data.
- mem_func3  out  3  memory access code.
- mem_we  out  1  memory write enable.
- mem_rdata  in  32  memory read data, one cycle after the address is presented.

## Operation
- Grant is combinational:
  - cpu_gnt = cpu_req & ~force_flt.
  - flt_gnt = flt_req & (~cpu_req | force_flt).
- Both grants are forced to 0 while rst is low.
- CPU grant: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_func3=cpu_func3, mem_we=cpu_we.
- Filter grant: mem_addr=flt_addr, mem_wdata=0, mem_func3=3'b010, mem_we=0.
- No grant: mem_addr=0, mem_wdata=0, mem_func3=0, mem_we=0.
- Owner tag register rd_owner ∈ {NONE, CPU, FLT}:
  - Set to CPU on a CPU load grant.
  - Set to FLT on a filter grant.
  - Set to NONE otherwise, including on a CPU store.
- Return path:
  - cpu_rvalid = (rd_owner==CPU); flt_rvalid = (rd_owner==FLT).
  - Both cpu_rdata and flt_rdata pass mem_rdata through when their own rvalid is set, and drive 0 otherwise.
- Starvation counter starve_cnt, 4 bits (only with the macro):
  - Increments when flt_req & ~flt_gnt, saturating at STARVE_LIMIT.
  - Clears when flt_gnt or ~flt_req.
  - force_flt = (starve_cnt == STARVE_LIMIT).
- Misaligned filter addresses (flt_addr[1:0] != 0) are forwarded unchanged; alignment is the requester's responsibility.

## Timing
- Reset values:
  - rd_owner=NONE, starve_cnt=0.
  - cpu_rvalid=0, flt_rvalid=0, cpu_rdata=0, flt_rdata=0, flt_gnt=0, cpu_stall=0.
  - mem_we=0, mem_addr=0.
- Latency:
  - Request to grant: 0 cycles.
  - Grant cycle N to rvalid: cycle N+1.
- A grant is held for exactly one cycle per accepted request. The requester must hold req/addr stable while ungranted.
- Simultaneous requests: CPU wins unless force_flt. In the force_flt cycle the filter wins and cpu_stall=1.
- Back-to-back grants are allowed every cycle. An rvalid for cycle N's grant coexists with cycle N+1's grant.
- Reset asserted mid-read clears rd_owner, so the pending rvalid is dropped and never delivered after reset release.
- First grant is possible in the first posedge-evaluated cycle with rst high.

## Configuration
- DMEM_ARB_STARVE_GUARD_EN defined:
  - starve_cnt is implemented.
  - A filter request denied for STARVE_LIMIT consecutive cycles is granted in the next cycle.
- DMEM_ARB_STARVE_GUARD_EN undefined:
  - No counter exists and force_flt is constant 0.
  - Arbitration is strict CPU priority; the filter waits while cpu_req stays high.

## Test plan
- CPU load only: cpu_req=1, cpu_we=0, cpu_addr=0x40, memory word 0x11223344 -> same cycle cpu_stall=0, mem_addr=0x40, mem_we=0; next cycle cpu_rvalid=1, cpu_rdata=0x11223344, flt_rvalid=0.
- CPU store: cpu_we=1, cpu_func3=3'b000, cpu_wdata=0xAB, cpu_addr=0x13 -> mem_we=1, mem_func3=3'b000, mem_addr=0x13; no rvalid on either port next cycle.
- Filter only: flt_req=1, flt_addr=0x100, memory word 0xDEADBEEF -> flt_gnt=1, mem_func3=3'b010; next cycle flt_rvalid=1, flt_rdata=0xDEADBEEF.
- Collision, guard defined, STARVE_LIMIT=4: cpu_req and flt_req held high ->
  - Cycles 0-3: CPU granted, flt_gnt=0.
  - Cycle 4: flt_gnt=1, cpu_stall=1.
  - Cycle 5: CPU granted again and starve_cnt=0.
  - Without the macro, flt_gnt stays 0 for 20 cycles.
- Reset mid-read: filter granted at cycle N, rst pulled low before cycle N+1 -> flt_rvalid=0 throughout reset; after release, no rvalid until a new grant.
- Back-to-back alternating: CPU load at N, filter read at N+1 (cpu_req low) -> cpu_rvalid at N+1, flt_rvalid at N+2, each carrying its own address's data.
